// File: rtl/rca_lsq_if.sv
// rca_lsq_if: request, response and memory-side signals of the load/store queue.
interface rca_lsq_if #(parameter int XLEN = 32) ();
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] data;
  logic [2:0]      fn3;
  logic            load;
  logic            store;
  logic            new_request;
  logic            lsq_full;
  logic [XLEN-1:0] load_data;
  logic            load_complete;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  modport slave (
    input  addr, data, fn3, load, store, new_request, mem_ack, mem_rvalid, mem_rdata,
    output lsq_full, load_data, load_complete, mem_req, mem_addr, mem_we, mem_be, mem_wdata
  );
  modport master (
    output addr, data, fn3, load, store, new_request, mem_ack, mem_rvalid, mem_rdata,
    input  lsq_full, load_data, load_complete, mem_req, mem_addr, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/rca_lsq.sv
// rca_lsq: in-order load/store queue issuing one memory access at a time, one load outstanding.
module rca_lsq #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic       clk,
  input logic       rst,
  rca_lsq_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic {READY, WAIT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] addr_m [DEPTH];
  logic [XLEN-1:0] data_m [DEPTH];
  logic [2:0]      fn3_m  [DEPTH];
  logic [DEPTH-1:0] load_m;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic full_q, lc_q;
  logic [1:0] off_q;
  logic [2:0] lfn3_q;
  logic [XLEN-1:0] ld_q, ld_d, h_addr, h_data;
  logic [2:0] h_fn3;
  logic h_load, busy, push, pop, s_b, s_h;
  logic [7:0] lb;
  logic [15:0] lh;
  always_comb begin
    h_addr  = addr_m[rptr_q];
    h_data  = data_m[rptr_q];
    h_fn3   = fn3_m[rptr_q];
    h_load  = load_m[rptr_q];
    busy    = count_q != '0;
    push    = bus.new_request && (bus.load ^ bus.store) && !full_q;
    pop     = state_q == READY && busy && bus.mem_ack;
    count_d = count_q + CW'(push) - CW'(pop);
    state_d = state_q == READY ? (pop && h_load ? WAIT : READY) : (bus.mem_rvalid ? READY : WAIT);
    s_b     = h_fn3 inside {3'b000, 3'b100};
    s_h     = h_fn3 inside {3'b001, 3'b101};
    lb      = 8'(bus.mem_rdata >> {off_q, 3'b000});
    lh      = 16'(bus.mem_rdata >> {off_q[1], 4'b0000});
    ld_d    = lfn3_q == 3'b000 ? {{(XLEN-8){lb[7]}}, lb} :
              lfn3_q == 3'b001 ? {{(XLEN-16){lh[15]}}, lh} :
              lfn3_q == 3'b100 ? {{(XLEN-8){1'b0}}, lb} :
              lfn3_q == 3'b101 ? {{(XLEN-16){1'b0}}, lh} : bus.mem_rdata;
  end
  assign bus.mem_req       = state_q == READY && busy;
  assign bus.mem_addr      = {h_addr[XLEN-1:2], 2'b00};
  assign bus.mem_we        = !h_load;
  assign bus.mem_be        = h_load ? 4'b1111 : s_b ? 4'b0001 << h_addr[1:0] :
                             s_h ? (h_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign bus.mem_wdata     = s_b ? {(XLEN/8){h_data[7:0]}} : s_h ? {(XLEN/16){h_data[15:0]}} : h_data;
  assign bus.lsq_full      = full_q;
  assign bus.load_complete = lc_q;
  assign bus.load_data     = ld_q;
  // Entry storage needs no reset: count and pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_m[wptr_q] <= bus.addr;
      data_m[wptr_q] <= bus.data;
      fn3_m[wptr_q]  <= bus.fn3;
      load_m[wptr_q] <= bus.load;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= READY;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      off_q   <= '0;
      lfn3_q  <= '0;
      lc_q    <= 1'b0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= count_d == FULL;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop) rptr_q <= rptr_q + PW'(1);
      if (pop && h_load) begin
        off_q  <= h_addr[1:0];
        lfn3_q <= h_fn3;
      end
      lc_q <= state_q == WAIT && bus.mem_rvalid;
      if (state_q == WAIT && bus.mem_rvalid) ld_q <= ld_d;
    end
  end
endmodule
